// File: rtl/mem_pkg.sv
// Shared definitions for the two-port RAM arbiter: command encoding, defaults,
// owner-state encoding and the request-qualify helper.
package mem_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    // A port requests RAM only with a read/write command in the lower half of the address map.
    function automatic logic is_req(input logic [1:0] cmd, input logic addr_msb);
        return ((cmd == MREAD) || (cmd == MWRITE)) && !addr_msb;
    endfunction

endpackage

// File: rtl/mem_arb_fsm.sv
// Round-robin owner tracker with bounded burst hold; grants are combinational
// from the current owner state and the two requests.
module mem_arb_fsm
    import mem_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    arb_state_t state_r;
    logic [3:0] burst_cnt_r;
    logic       last_r;
    logic       gnt0_s;
    logic       gnt1_s;

    // Grant decision: owner keeps the RAM until its burst is spent and the other port waits.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt0_s = last_r;
                        gnt1_s = !last_r;
                    end else begin
                        gnt0_s = req0;
                        gnt1_s = req1;
                    end
                end
                OWN0: begin
                    if (req0 && (!req1 || (burst_cnt_r < BURST_MAX))) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = req1;
                    end
                end
                OWN1: begin
                    if (req1 && (!req0 || (burst_cnt_r < BURST_MAX))) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = req0;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;

    // Owner state, saturating burst count and last-owner tie breaker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            burst_cnt_r <= 4'd0;
            last_r      <= 1'b1;
        end else if (gnt0_s) begin
            state_r     <= OWN0;
            last_r      <= 1'b0;
            if (state_r == OWN0) begin
                burst_cnt_r <= (burst_cnt_r >= BURST_MAX) ? BURST_MAX : burst_cnt_r + 4'd1;
            end else begin
                burst_cnt_r <= 4'd1;
            end
        end else if (gnt1_s) begin
            state_r     <= OWN1;
            last_r      <= 1'b1;
            if (state_r == OWN1) begin
                burst_cnt_r <= (burst_cnt_r >= BURST_MAX) ? BURST_MAX : burst_cnt_r + 4'd1;
            end else begin
                burst_cnt_r <= 4'd1;
            end
        end else begin
            state_r     <= IDLE;
            burst_cnt_r <= burst_cnt_r;
            last_r      <= last_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM.
// Optional MEM_ARB_STATS_EN adds saturating per-port grant counters.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        p0_cmd,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic [1:0]        p1_cmd,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic [ADDR_W-2:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       p0_grants,
    output logic [15:0]       p1_grants
`endif
);

    logic req0_s, req1_s, gnt0_s, gnt1_s;
    logic rd0_r, rd1_r;

    assign req0_s = is_req(p0_cmd, p0_addr[ADDR_W-1]);
    assign req1_s = is_req(p1_cmd, p1_addr[ADDR_W-1]);

    mem_arb_fsm #(.BURST_LEN(BURST_LEN)) u_fsm (
        .clk   (clk),
        .reset (reset),
        .req0  (req0_s),
        .req1  (req1_s),
        .gnt0  (gnt0_s),
        .gnt1  (gnt1_s)
    );

    // RAM-side mux; without a grant the port 0 fields pass through with the write disabled.
    always_comb begin
        ram_addr  = p0_addr[ADDR_W-2:0];
        ram_din   = p0_wdata;
        ram_write = 1'b0;
        if (gnt1_s) begin
            ram_addr  = p1_addr[ADDR_W-2:0];
            ram_din   = p1_wdata;
            ram_write = (p1_cmd == MWRITE);
        end else if (gnt0_s) begin
            ram_write = (p0_cmd == MWRITE);
        end else begin
            ram_write = 1'b0;
        end
    end

    assign p0_ack = gnt0_s;
    assign p1_ack = gnt1_s;

    // Remember which port read so the RAM's registered output is steered back next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd0_r <= 1'b0;
            rd1_r <= 1'b0;
        end else begin
            rd0_r <= gnt0_s && (p0_cmd == MREAD);
            rd1_r <= gnt1_s && (p1_cmd == MREAD);
        end
    end

    // Reset masks a return already in flight so a read acked just before reset is dropped.
    assign p0_rvalid = rd0_r && !reset;
    assign p1_rvalid = rd1_r && !reset;
    assign p0_rdata  = p0_rvalid ? ram_dout : {DATA_W{1'b0}};
    assign p1_rdata  = p1_rvalid ? ram_dout : {DATA_W{1'b0}};

`ifdef MEM_ARB_STATS_EN
    // Saturating per-port access counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_grants <= 16'd0;
            p1_grants <= 16'd0;
        end else begin
            if (gnt0_s && (p0_grants != 16'hFFFF)) begin
                p0_grants <= p0_grants + 16'd1;
            end
            if (gnt1_s && (p1_grants != 16'hFFFF)) begin
                p1_grants <= p1_grants + 16'd1;
            end
        end
    end
`endif

endmodule
